// File: rtl/seg7_display.sv
// Single-digit hex seven-segment decoder with registered, polarity-selectable segment and DP drive.
// Optional lamp test input is enabled by defining SEG7_DISPLAY_LAMP_TEST_EN.
module seg7_display #(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
`ifdef SEG7_DISPLAY_LAMP_TEST_EN
  input  logic       i_lamp_test,
`endif
  input  logic [3:0] i_data,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  localparam logic POL_LOW = (SEG_ACTIVE_LOW != 0);

  logic [6:0] w_decoded;
  logic [6:0] w_lit;
  logic       w_ldp;
  logic [6:0] w_pin_seg;
  logic       w_pin_dp;
  logic [6:0] r_seg;
  logic       r_dp;

  // Logical lit pattern {g,f,e,d,c,b,a}; b and d are lower-case glyphs.
  always_comb begin
    w_decoded = '0;
    unique case (i_data)
      4'h0: w_decoded = 7'h3F;
      4'h1: w_decoded = 7'h06;
      4'h2: w_decoded = 7'h5B;
      4'h3: w_decoded = 7'h4F;
      4'h4: w_decoded = 7'h66;
      4'h5: w_decoded = 7'h6D;
      4'h6: w_decoded = 7'h7D;
      4'h7: w_decoded = 7'h07;
      4'h8: w_decoded = 7'h7F;
      4'h9: w_decoded = 7'h6F;
      4'hA: w_decoded = 7'h77;
      4'hB: w_decoded = 7'h7C;
      4'hC: w_decoded = 7'h39;
      4'hD: w_decoded = 7'h5E;
      4'hE: w_decoded = 7'h79;
      4'hF: w_decoded = 7'h71;
      default: w_decoded = '0;
    endcase
  end

  // Override priority: lamp test, then blank, then normal decode.
  always_comb begin
    w_lit = w_decoded;
    w_ldp = i_dp;
    if (i_blank) begin
      w_lit = '0;
      w_ldp = 1'b0;
    end
`ifdef SEG7_DISPLAY_LAMP_TEST_EN
    if (i_lamp_test) begin
      w_lit = '1;
      w_ldp = 1'b1;
    end
`endif
  end

  assign w_pin_seg = w_lit ^ {7{POL_LOW}};
  assign w_pin_dp  = w_ldp ^ POL_LOW;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_seg <= {7{POL_LOW}};
      r_dp  <= POL_LOW;
    end else begin
      r_seg <= w_pin_seg;
      r_dp  <= w_pin_dp;
    end
  end

  assign o_seg = r_seg;
  assign o_dp  = r_dp;

endmodule

// File: tb/tb_seg7_display.sv
// Randomized self-checking bench for seg7_display: both polarities checked each cycle against
// a behavioural model, plus literal expectations from the active-low image table.
module tb_seg7_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data;
  logic       dp;
  logic       blank;
  logic       lamp;
  logic [6:0] seg_al, seg_ah;
  logic       dp_al, dp_ah;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_display #(.SEG_ACTIVE_LOW(1)) u_dut_al (
    .i_clk(clk), .i_rst(rst),
`ifdef SEG7_DISPLAY_LAMP_TEST_EN
    .i_lamp_test(lamp),
`endif
    .i_data(data), .i_dp(dp), .i_blank(blank), .o_seg(seg_al), .o_dp(dp_al)
  );

  seg7_display #(.SEG_ACTIVE_LOW(0)) u_dut_ah (
    .i_clk(clk), .i_rst(rst),
`ifdef SEG7_DISPLAY_LAMP_TEST_EN
    .i_lamp_test(lamp),
`endif
    .i_data(data), .i_dp(dp), .i_blank(blank), .o_seg(seg_ah), .o_dp(dp_ah)
  );

  // Logical lit patterns (1 = lit) and the published active-low pin images.
  logic [6:0] lit_tbl [16];
  logic [6:0] al_img  [16];
  initial begin
    lit_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    al_img  = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  // Model: what the lit segments/DP must be one clock after the sampled inputs.
  logic [6:0] m_lit;
  logic       m_ldp;
  logic       m_valid = 1'b0;
  logic       lamp_eff;

  always_comb begin
    lamp_eff = 1'b0;
`ifdef SEG7_DISPLAY_LAMP_TEST_EN
    lamp_eff = lamp;
`endif
  end

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (rst) begin
      m_lit <= 7'h00;
      m_ldp <= 1'b0;
    end else if (lamp_eff) begin
      m_lit <= 7'h7F;
      m_ldp <= 1'b1;
    end else if (blank) begin
      m_lit <= 7'h00;
      m_ldp <= 1'b0;
    end else begin
      m_lit <= lit_tbl[data];
      m_ldp <= dp;
    end
  end

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_seg_al", seg_al, ~m_lit);
      check("model_dp_al", {6'b0, dp_al}, {6'b0, ~m_ldp});
      check("model_seg_ah", seg_ah, m_lit);
      check("model_dp_ah", {6'b0, dp_ah}, {6'b0, m_ldp});
    end
  end

  task automatic drive(input logic r, input logic [3:0] d, input logic p, input logic b, input logic l);
    @(negedge clk);
    rst = r; data = d; dp = p; blank = b; lamp = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; data = 4'h8; dp = 1'b0; blank = 1'b0; lamp = 1'b0;
    tick(); tick();
    check("rst_seg_al", seg_al, 7'h7F);
    check("rst_dp_al", {6'b0, dp_al}, 7'h01);
    check("rst_seg_ah", seg_ah, 7'h00);
    check("rst_dp_ah", {6'b0, dp_ah}, 7'h00);

    drive(1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
    tick();
    check("release_seg", seg_al, 7'h00);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'(i), 1'b0, 1'b0, 1'b0);
      tick();
      check("sweep_seg", seg_al, al_img[i]);
      check("sweep_dp", {6'b0, dp_al}, 7'h01);
    end

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 4'h5, t[0], 1'b0, 1'b0);
        tick();
        check("dptog_seg", seg_al, 7'h12);
        check("dptog_dp", {6'b0, dp_al}, {6'b0, ~t[0]});
      end
    end

    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    tick();
    check("blank_seg", seg_al, 7'h7F);
    check("blank_dp", {6'b0, dp_al}, 7'h01);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    tick();
    check("unblank_seg", seg_al, 7'h40);
    check("unblank_dp", {6'b0, dp_al}, 7'h00);

    drive(1'b0, 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    check("ah_seg", seg_ah, 7'h5B);
    check("ah_dp", {6'b0, dp_ah}, 7'h01);
    drive(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
    tick();
    check("ah_rst_seg", seg_ah, 7'h00);
    check("ah_rst_dp", {6'b0, dp_ah}, 7'h00);

`ifdef SEG7_DISPLAY_LAMP_TEST_EN
    drive(1'b0, 4'h3, 1'b0, 1'b1, 1'b1);
    tick();
    check("lamp_seg", seg_al, 7'h00);
    check("lamp_dp", {6'b0, dp_al}, 7'h00);
    drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
    tick();
    check("lamp_rst_seg", seg_al, 7'h7F);
`endif

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0));
    end
    tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
